// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets NUM_REQ producers take turns
// writing bursts of up to MAX_BURST beats into one shared FIFO write port.
// Arbitration takes one IDLE cycle. The selected producer then owns the port
// until its last beat, its MAX_BURST-th beat, or the cycle it drops valid.
//
// Handshake: a producer beat transfers on the rising edge where
// req_valid[i] & req_ready[i] are both high. req_ready[i] is high only for the
// current owner while the FIFO is not full, and it does not depend on
// req_valid. A producer may raise valid at any time. Once it is granted it
// must keep valid high until its burst ends. Dropping valid while granted
// releases the grant. fifo_w_en is the FIFO-side strobe: one write per cycle
// in which it is high.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_last,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_w_en,
  output logic [WIDTH-1:0]         fifo_w_data,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic [0:0]               dbg_state_o,
  output logic [CNT_W-1:0]         dbg_beat_cnt_o,
  output logic [ID_W-1:0]          dbg_last_grant_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [ID_W-1:0]  scan_idx;
  logic [ID_W-1:0]  pick_id;
  logic             pick_found;

  logic             active;
  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;
  logic             accept;
  logic             burst_full;
  logic             grant_exit;

  // Round-robin search: walk upward from the slot after last_grant, wrapping,
  // and take the first producer with valid set.
  always_comb begin
    scan_idx   = last_grant_q;
    pick_id    = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = (scan_idx == ID_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  // Owner-side view of the port.
  // Outputs are forced low while rst_n is low, so nothing is written during
  // a reset cycle, even one that lands mid-burst.
  always_comb begin
    active      = rst_n & (state_q == ST_GRANT);
    g_valid     = req_valid[grant_id_q];
    g_last      = req_last[grant_id_q];
    g_data      = req_data[int'(grant_id_q)*WIDTH +: WIDTH];
    accept      = active & g_valid & ~fifo_full;
    burst_full  = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
    grant_exit  = active & (~g_valid | (accept & (g_last | burst_full)));
    busy        = active;
    fifo_w_en   = accept;
    fifo_w_data = active ? g_data : '0;
    req_ready   = '0;
    if (active && !fifo_full) begin
      req_ready[grant_id_q] = 1'b1;
    end
  end

  // Next-state logic for the IDLE/GRANT controller, beat counter and
  // round-robin pointer.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_GRANT;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (grant_exit) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_id_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. Reset points last_grant at the top slot so producer 0
  // wins the first arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign grant_id         = grant_id_q;
  assign dbg_state_o      = state_q;
  assign dbg_beat_cnt_o   = beat_cnt_q;
  assign dbg_last_grant_o = last_grant_q;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of producers sharing one FIFO write port (2..8).
REQ-002 Parameter WIDTH, default 8: data width per beat.
REQ-003 Parameter MAX_BURST, default 4: maximum beats per grant (1..16).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-producer beat valid.
REQ-007 req_last  input  NUM_REQ  per-producer last beat of burst, qualified by req_valid.
REQ-008 req_data  input  NUM_REQ*WIDTH  producer i data in bits [i*WIDTH +: WIDTH].
REQ-009 req_ready  output  NUM_REQ  per-producer beat accepted this cycle when valid&ready.
REQ-010 fifo_full  input  1  full flag from the downstream FIFO.
REQ-011 fifo_w_en  output  1  FIFO write enable.
REQ-012 fifo_w_data  output  WIDTH  FIFO write data.
REQ-013 grant_id  output  $clog2(NUM_REQ)  index of current owner; meaningful only when busy=1.
REQ-014 busy  output  1  high while a grant is held (state GRANT).

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and GRANT, held in registers.
REQ-016 In IDLE with any req_valid bit high, the block SHALL select the first set bit searching upward from (last_grant+1) mod NUM_REQ, wrapping, register it in grant_id, and enter GRANT next cycle.
REQ-017 In IDLE, req_ready SHALL be all zero and fifo_w_en zero; arbitration costs exactly one cycle.
REQ-018 In IDLE with no req_valid bit set, the FSM SHALL remain in IDLE and last_grant SHALL be unchanged.
REQ-019 In GRANT, req_ready[grant_id] SHALL equal ~fifo_full combinationally; all other req_ready bits SHALL be 0.
REQ-020 In GRANT, fifo_w_en SHALL equal req_valid[grant_id] & ~fifo_full, and fifo_w_data SHALL equal the grant_id slice of req_data.
REQ-021 A beat count SHALL increment by 1 on each accepted beat (fifo_w_en=1) and clear on entry to GRANT.
REQ-022 GRANT SHALL exit to IDLE after the accepted beat carrying req_last[grant_id]=1.
REQ-023 GRANT SHALL exit to IDLE after the accepted beat that brings the beat count to MAX_BURST, regardless of req_last.
REQ-024 GRANT SHALL exit to IDLE in any cycle where req_valid[grant_id]=0 (producer released); no beat is written that cycle.
REQ-025 While fifo_full=1 in GRANT with req_valid[grant_id]=1, the block SHALL hold state, beat count and grant (stall), writing nothing.
REQ-026 On every GRANT exit, last_grant SHALL be updated to grant_id.
REQ-027 No producer with req_valid held high SHALL wait more than (NUM_REQ-1) grants before being granted.
REQ-028 Requests and data from non-granted producers SHALL be ignored; no beat SHALL be written to the FIFO without a matching req_ready.

Reset
REQ-029 When rst_n=0 at a rising edge: state=IDLE, beat count=0, grant_id=0, last_grant=NUM_REQ-1 (so producer 0 has first priority).
REQ-030 During and immediately after reset: req_ready=0, fifo_w_en=0, fifo_w_data=0, busy=0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst; the next arbitration SHALL restart from producer 0.

Verification
REQ-032 Post reset, req_valid=4'b1111, no req_last, fifo_full=0 -> grants 0,1,2,3,0 each of 4 beats, one idle cycle between grants.
REQ-033 Producer 2 only, 2-beat burst with req_last on beat 2 -> grant_id=2, fifo_w_en high 2 cycles, FIFO receives the two data words in order, then busy=0.
REQ-034 Producer 1 granted, fifo_full high 3 cycles after beat 1 -> req_ready[1]=0 and fifo_w_en=0 for 3 cycles, beat count stays 1, burst completes after full drops.
REQ-035 Producer 3 granted, req_valid[3] drops after 1 beat -> exit to IDLE, last_grant=3, next grant goes to producer 0 if requesting.
REQ-036 rst_n low during beat 2 of producer 1 burst -> all outputs 0 next cycle; with req_valid=4'b0010|4'b0001 afterwards, producer 0 granted first.
